// File: rtl/cpu_pipeline_v2_core.sv
// Five-stage RV32I integer pipeline (IF/ID/EX/MEM/WB) with forwarding, load-use stall and branch flush.
// Fetch and data ports are word-wide with same-cycle read data.
module cpu_pipeline_v2_core #(
  parameter int ADDR_WIDTH          = 32,
  parameter int DATA_WIDTH          = 32,
  parameter int REG_FILE_ADDR_WIDTH = 5
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic [DATA_WIDTH-1:0] pfm_rd_instr,
  input  logic [DATA_WIDTH-1:0] dfm_rd_data,
  output logic [ADDR_WIDTH-1:0] pfm_req_addr,
  output logic [ADDR_WIDTH-1:0] dfm_req_addr,
  output logic                  dfm_wr_en,
  output logic [DATA_WIDTH-1:0] dfm_wr_data
);
  localparam int NREGS = 1 << REG_FILE_ADDR_WIDTH;
  typedef logic [REG_FILE_ADDR_WIDTH-1:0] ridx_t;
  typedef logic [DATA_WIDTH-1:0]          word_t;
  typedef logic [ADDR_WIDTH-1:0]          addr_t;

  typedef enum logic [6:0] {
    OP_LUI    = 7'b0110111,
    OP_AUIPC  = 7'b0010111,
    OP_JAL    = 7'b1101111,
    OP_JALR   = 7'b1100111,
    OP_BRANCH = 7'b1100011,
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_IMM    = 7'b0010011,
    OP_REG    = 7'b0110011
  } opcode_e;

  word_t regs_q [NREGS];
  addr_t pc_q;
  logic  ifid_valid_q, idex_valid_q;
  addr_t ifid_pc_q, idex_pc_q;
  word_t ifid_instr_q, idex_instr_q, idex_rv1_q, idex_rv2_q;
  logic  exmem_wb_q, exmem_load_q, exmem_store_q, memwb_wb_q;
  ridx_t exmem_rd_q, memwb_rd_q;
  word_t exmem_res_q, exmem_sd_q, memwb_data_q;

  // ID stage: operand read with WB write-through, load-use detection
  logic [6:0] id_op;
  ridx_t      id_rs1, id_rs2;
  logic       id_use_rs1, id_use_rs2, stall;
  word_t      id_rv1, id_rv2;

  // EX stage
  logic [6:0] ex_op;
  logic [2:0] ex_f3;
  logic       ex_alt, ex_wb, ex_load, ex_store, ex_taken, ex_cond;
  ridx_t      ex_rs1, ex_rs2, ex_rd;
  word_t      imm_i, imm_s, imm_b, imm_u, imm_j;
  word_t      op_a, op_b, alu_b, alu_res, ex_res;
  addr_t      ex_target;
  word_t      mem_data;

  always_comb begin
    ex_op   = idex_instr_q[6:0];
    ex_f3   = idex_instr_q[14:12];
    ex_alt  = idex_instr_q[30];
    ex_rd   = idex_instr_q[11:7];
    ex_rs1  = idex_instr_q[19:15];
    ex_rs2  = idex_instr_q[24:20];
    imm_i   = {{20{idex_instr_q[31]}}, idex_instr_q[31:20]};
    imm_s   = {{20{idex_instr_q[31]}}, idex_instr_q[31:25], idex_instr_q[11:7]};
    imm_b   = {{19{idex_instr_q[31]}}, idex_instr_q[31], idex_instr_q[7],
               idex_instr_q[30:25], idex_instr_q[11:8], 1'b0};
    imm_u   = {idex_instr_q[31:12], 12'h000};
    imm_j   = {{11{idex_instr_q[31]}}, idex_instr_q[31], idex_instr_q[19:12],
               idex_instr_q[20], idex_instr_q[30:21], 1'b0};

    // EX/MEM wins over MEM/WB; loads in EX/MEM never forward because the stall covers them
    if (exmem_wb_q && !exmem_load_q && exmem_rd_q == ex_rs1)  op_a = exmem_res_q;
    else if (memwb_wb_q && memwb_rd_q == ex_rs1)              op_a = memwb_data_q;
    else                                                      op_a = idex_rv1_q;
    if (exmem_wb_q && !exmem_load_q && exmem_rd_q == ex_rs2)  op_b = exmem_res_q;
    else if (memwb_wb_q && memwb_rd_q == ex_rs2)              op_b = memwb_data_q;
    else                                                      op_b = idex_rv2_q;

    alu_b = (ex_op == OP_REG) ? op_b : imm_i;
    unique case (ex_f3)
      3'b000:  alu_res = (ex_op == OP_REG && ex_alt) ? op_a - alu_b : op_a + alu_b;
      3'b001:  alu_res = op_a << alu_b[4:0];
      3'b010:  alu_res = word_t'($signed(op_a) < $signed(alu_b));
      3'b011:  alu_res = word_t'(op_a < alu_b);
      3'b100:  alu_res = op_a ^ alu_b;
      3'b101:  alu_res = ex_alt ? word_t'($signed(op_a) >>> alu_b[4:0]) : op_a >> alu_b[4:0];
      3'b110:  alu_res = op_a | alu_b;
      default: alu_res = op_a & alu_b;
    endcase

    unique case (ex_f3)
      3'b000:  ex_cond = (op_a == op_b);
      3'b001:  ex_cond = (op_a != op_b);
      3'b100:  ex_cond = ($signed(op_a) < $signed(op_b));
      3'b101:  ex_cond = ($signed(op_a) >= $signed(op_b));
      3'b110:  ex_cond = (op_a < op_b);
      3'b111:  ex_cond = (op_a >= op_b);
      default: ex_cond = 1'b0;
    endcase

    ex_wb     = 1'b0;
    ex_load   = 1'b0;
    ex_store  = 1'b0;
    ex_taken  = 1'b0;
    ex_res    = alu_res;
    ex_target = idex_pc_q + imm_b;
    if (idex_valid_q) begin
      case (ex_op)
        OP_LUI:    begin ex_wb = 1'b1; ex_res = imm_u; end
        OP_AUIPC:  begin ex_wb = 1'b1; ex_res = idex_pc_q + imm_u; end
        OP_JAL:    begin
          ex_wb = 1'b1; ex_res = idex_pc_q + 4; ex_taken = 1'b1; ex_target = idex_pc_q + imm_j;
        end
        OP_JALR:   begin
          ex_wb = 1'b1; ex_res = idex_pc_q + 4; ex_taken = 1'b1;
          ex_target = (op_a + imm_i) & ~word_t'(1);
        end
        OP_BRANCH: ex_taken = ex_cond;
        OP_LOAD:   if (ex_f3 == 3'b010) begin
          ex_wb = 1'b1; ex_load = 1'b1; ex_res = op_a + imm_i;
        end
        OP_STORE:  if (ex_f3 == 3'b010) begin
          ex_store = 1'b1; ex_res = op_a + imm_s;
        end
        OP_IMM, OP_REG: ex_wb = 1'b1;
        default: ;
      endcase
    end
    if (ex_rd == '0) begin
      ex_wb   = 1'b0;
      ex_load = 1'b0;
    end
  end

  always_comb begin
    id_op      = ifid_instr_q[6:0];
    id_rs1     = ifid_instr_q[19:15];
    id_rs2     = ifid_instr_q[24:20];
    id_use_rs1 = id_op inside {OP_JALR, OP_BRANCH, OP_LOAD, OP_STORE, OP_IMM, OP_REG};
    id_use_rs2 = id_op inside {OP_BRANCH, OP_STORE, OP_REG};
    stall      = ifid_valid_q && ex_load &&
                 ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
    if (id_rs1 == '0)                                 id_rv1 = '0;
    else if (memwb_wb_q && memwb_rd_q == id_rs1)      id_rv1 = memwb_data_q;
    else                                              id_rv1 = regs_q[id_rs1];
    if (id_rs2 == '0)                                 id_rv2 = '0;
    else if (memwb_wb_q && memwb_rd_q == id_rs2)      id_rv2 = memwb_data_q;
    else                                              id_rv2 = regs_q[id_rs2];
    mem_data = exmem_load_q ? dfm_rd_data : exmem_res_q;
  end

  // Flush takes precedence over stall: a taken jump discards the stalled successor anyway
  always_ff @(posedge sys_clk or posedge sys_rst_n) begin
    if (sys_rst_n) begin
      pc_q          <= '0;
      ifid_valid_q  <= 1'b0;
      ifid_pc_q     <= '0;
      ifid_instr_q  <= '0;
      idex_valid_q  <= 1'b0;
      idex_pc_q     <= '0;
      idex_instr_q  <= '0;
      idex_rv1_q    <= '0;
      idex_rv2_q    <= '0;
      exmem_wb_q    <= 1'b0;
      exmem_load_q  <= 1'b0;
      exmem_store_q <= 1'b0;
      exmem_rd_q    <= '0;
      exmem_res_q   <= '0;
      exmem_sd_q    <= '0;
      memwb_wb_q    <= 1'b0;
      memwb_rd_q    <= '0;
      memwb_data_q  <= '0;
    end else begin
      if (ex_taken)    pc_q <= ex_target;
      else if (!stall) pc_q <= pc_q + 4;

      if (ex_taken) begin
        ifid_valid_q <= 1'b0;
      end else if (!stall) begin
        ifid_valid_q <= 1'b1;
        ifid_pc_q    <= pc_q;
        ifid_instr_q <= pfm_rd_instr;
      end

      if (ex_taken || stall) begin
        idex_valid_q <= 1'b0;
      end else begin
        idex_valid_q <= ifid_valid_q;
        idex_pc_q    <= ifid_pc_q;
        idex_instr_q <= ifid_instr_q;
        idex_rv1_q   <= id_rv1;
        idex_rv2_q   <= id_rv2;
      end

      exmem_wb_q    <= ex_wb;
      exmem_load_q  <= ex_load;
      exmem_store_q <= ex_store;
      exmem_rd_q    <= ex_rd;
      exmem_res_q   <= ex_res;
      exmem_sd_q    <= op_b;

      memwb_wb_q    <= exmem_wb_q;
      memwb_rd_q    <= exmem_rd_q;
      memwb_data_q  <= mem_data;
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst_n) begin
    if (sys_rst_n) begin
      for (int unsigned i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (memwb_wb_q) begin
      regs_q[memwb_rd_q] <= memwb_data_q;
    end
  end

  assign pfm_req_addr = pc_q;
  assign dfm_req_addr = exmem_res_q;
  assign dfm_wr_en    = exmem_store_q;
  assign dfm_wr_data  = exmem_sd_q;
endmodule

// File: tb/tb_cpu_pipeline_v2_core.sv
// Directed-program bench for cpu_pipeline_v2_core: per-cycle bus trace checked against hand-computed values.
module tb_cpu_pipeline_v2_core;
  localparam int NCYC = 32;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] instr, rdata, pfm_addr, dfm_addr, wdata;
  logic        we;
  logic [31:0] imem [128];
  logic [31:0] dmem [64];
  logic [31:0] pc_tr [NCYC];
  logic [31:0] ad_tr [NCYC];
  logic [31:0] wd_tr [NCYC];
  logic        we_tr [NCYC];
  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  assign instr = imem[pfm_addr[8:2]];
  assign rdata = dmem[dfm_addr[7:2]];

  cpu_pipeline_v2_core #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .REG_FILE_ADDR_WIDTH(5)) dut (
    .sys_clk      (clk),
    .sys_rst_n    (rst),
    .pfm_rd_instr (instr),
    .dfm_rd_data  (rdata),
    .pfm_req_addr (pfm_addr),
    .dfm_req_addr (dfm_addr),
    .dfm_wr_en    (we),
    .dfm_wr_data  (wdata)
  );

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2, input logic [4:0] rs1);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
  endfunction
  function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6f};
  endfunction
  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction

  function automatic int we_count(input int lo, input int hi);
    int n = 0;
    for (int i = lo; i <= hi; i++) if (we_tr[i] === 1'b1) n++;
    return n;
  endfunction

  task automatic load_clear();
    for (int i = 0; i < 128; i++) imem[i] = NOP;
    for (int i = 0; i < 64; i++) dmem[i] = '0;
  endtask

  task automatic start();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Entry at the negedge of cycle 0; sample i is taken 1 time unit after the negedge of cycle i
  task automatic run_trace();
    for (int i = 0; i < NCYC; i++) begin
      #1;
      pc_tr[i] = pfm_addr; ad_tr[i] = dfm_addr; wd_tr[i] = wdata; we_tr[i] = we;
      @(negedge clk);
    end
  endtask

  task automatic load_prog_fwd();
    imem[0] = enc_i(12'd5, 5'd0, 3'b000, 5'd1, 7'h13);
    imem[1] = enc_i(12'd3, 5'd1, 3'b000, 5'd2, 7'h13);
    imem[2] = {20'h10000, 5'd3, 7'h37};
    imem[3] = enc_s(12'd0, 5'd2, 5'd3);
  endtask

  task automatic test_reset();
    load_clear();
    rst = 1'b1;
    @(posedge clk); #1;
    total_cnt++; if (pfm_addr !== 32'h0) $display("FAIL rst_pfm: got %h want %h", pfm_addr, 32'h0); else pass_cnt++;
    total_cnt++; if (we !== 1'b0) $display("FAIL rst_we: got %b want 0", we); else pass_cnt++;
    total_cnt++; if (dfm_addr !== 32'h0) $display("FAIL rst_daddr: got %h want %h", dfm_addr, 32'h0); else pass_cnt++;
    total_cnt++; if (wdata !== 32'h0) $display("FAIL rst_wdata: got %h want %h", wdata, 32'h0); else pass_cnt++;
    start();
    run_trace();
    for (int i = 0; i < 4; i++) begin
      total_cnt++;
      if (pc_tr[i] !== 32'(i * 4)) $display("FAIL nop_fetch%0d: got %h want %h", i, pc_tr[i], 32'(i * 4));
      else pass_cnt++;
    end
    total_cnt++; if (we_count(0, NCYC-1) !== 0) $display("FAIL nop_we: got %0d want 0", we_count(0, NCYC-1)); else pass_cnt++;
  endtask

  task automatic test_forward_store();
    load_clear();
    load_prog_fwd();
    start();
    run_trace();
    total_cnt++; if (we_tr[6] !== 1'b1) $display("FAIL fwd_we: got %b want 1", we_tr[6]); else pass_cnt++;
    total_cnt++; if (ad_tr[6] !== 32'h1000_0000) $display("FAIL fwd_addr: got %h want %h", ad_tr[6], 32'h1000_0000); else pass_cnt++;
    total_cnt++; if (wd_tr[6] !== 32'd8) $display("FAIL fwd_data: got %h want %h", wd_tr[6], 32'd8); else pass_cnt++;
    total_cnt++; if (we_count(0, NCYC-1) !== 1) $display("FAIL fwd_we_count: got %0d want 1", we_count(0, NCYC-1)); else pass_cnt++;
    total_cnt++; if (pc_tr[5] !== 32'h14) $display("FAIL fwd_steady_pc: got %h want %h", pc_tr[5], 32'h14); else pass_cnt++;
  endtask

  task automatic test_load_use();
    load_clear();
    load_prog_fwd();
    imem[4] = enc_i(12'd4, 5'd3, 3'b010, 5'd4, 7'h03);
    imem[5] = enc_r(7'h00, 5'd4, 5'd4, 3'b000, 5'd5);
    imem[6] = enc_s(12'd8, 5'd5, 5'd3);
    dmem[1] = 32'h55;
    start();
    run_trace();
    total_cnt++; if (pc_tr[6] !== 32'h18) $display("FAIL lu_pc6: got %h want %h", pc_tr[6], 32'h18); else pass_cnt++;
    total_cnt++; if (pc_tr[7] !== 32'h18) $display("FAIL lu_pc_hold: got %h want %h", pc_tr[7], 32'h18); else pass_cnt++;
    total_cnt++; if (pc_tr[8] !== 32'h1C) $display("FAIL lu_pc8: got %h want %h", pc_tr[8], 32'h1C); else pass_cnt++;
    total_cnt++; if (ad_tr[7] !== 32'h1000_0004 || we_tr[7] !== 1'b0) $display("FAIL lu_load_addr: got %h/%b want %h/0", ad_tr[7], we_tr[7], 32'h1000_0004); else pass_cnt++;
    total_cnt++; if (we_tr[10] !== 1'b1) $display("FAIL lu_st_we: got %b want 1", we_tr[10]); else pass_cnt++;
    total_cnt++; if (ad_tr[10] !== 32'h1000_0008) $display("FAIL lu_st_addr: got %h want %h", ad_tr[10], 32'h1000_0008); else pass_cnt++;
    total_cnt++; if (wd_tr[10] !== 32'hAA) $display("FAIL lu_st_data: got %h want %h", wd_tr[10], 32'hAA); else pass_cnt++;
    total_cnt++; if (we_count(0, NCYC-1) !== 2) $display("FAIL lu_we_count: got %0d want 2", we_count(0, NCYC-1)); else pass_cnt++;
  endtask

  task automatic test_branch();
    load_clear();
    imem[8]  = enc_b(13'd12, 5'd0, 5'd0, 3'b000);
    imem[9]  = enc_i(12'd1, 5'd0, 3'b000, 5'd8, 7'h13);
    imem[10] = enc_s(12'd0, 5'd0, 5'd0);
    imem[11] = enc_s(12'd64, 5'd8, 5'd0);
    start();
    run_trace();
    total_cnt++; if (pc_tr[10] !== 32'h28) $display("FAIL br_pc10: got %h want %h", pc_tr[10], 32'h28); else pass_cnt++;
    total_cnt++; if (pc_tr[11] !== 32'h2C) $display("FAIL br_target: got %h want %h", pc_tr[11], 32'h2C); else pass_cnt++;
    total_cnt++; if (we_tr[13] !== 1'b0) $display("FAIL br_flushed_store: got %b want 0", we_tr[13]); else pass_cnt++;
    total_cnt++; if (we_tr[14] !== 1'b1) $display("FAIL br_st_we: got %b want 1", we_tr[14]); else pass_cnt++;
    total_cnt++; if (ad_tr[14] !== 32'h40) $display("FAIL br_st_addr: got %h want %h", ad_tr[14], 32'h40); else pass_cnt++;
    total_cnt++; if (wd_tr[14] !== 32'h0) $display("FAIL br_flushed_regwr: got %h want %h", wd_tr[14], 32'h0); else pass_cnt++;
    total_cnt++; if (we_count(0, NCYC-1) !== 1) $display("FAIL br_we_count: got %0d want 1", we_count(0, NCYC-1)); else pass_cnt++;
  endtask

  task automatic test_jal_jalr();
    load_clear();
    imem[16] = enc_j(21'd16, 5'd1);
    imem[17] = enc_i(12'h033, 5'd0, 3'b000, 5'd10, 7'h13);
    imem[18] = enc_s(12'd4, 5'd10, 5'd0);
    imem[20] = enc_s(12'd0, 5'd1, 5'd0);
    imem[21] = enc_i(12'd0, 5'd1, 3'b000, 5'd0, 7'h67);
    start();
    run_trace();
    total_cnt++; if (pc_tr[19] !== 32'h50) $display("FAIL jal_target: got %h want %h", pc_tr[19], 32'h50); else pass_cnt++;
    total_cnt++; if (we_tr[21] !== 1'b0) $display("FAIL jal_flushed_store: got %b want 0", we_tr[21]); else pass_cnt++;
    total_cnt++; if (we_tr[22] !== 1'b1 || ad_tr[22] !== 32'h0) $display("FAIL jal_st: got %b/%h want 1/%h", we_tr[22], ad_tr[22], 32'h0); else pass_cnt++;
    total_cnt++; if (wd_tr[22] !== 32'h44) $display("FAIL jal_link: got %h want %h", wd_tr[22], 32'h44); else pass_cnt++;
    total_cnt++; if (pc_tr[23] !== 32'h44) $display("FAIL jalr_target: got %h want %h", pc_tr[23], 32'h44); else pass_cnt++;
    total_cnt++; if (we_tr[27] !== 1'b1 || ad_tr[27] !== 32'h4) $display("FAIL jalr_st: got %b/%h want 1/%h", we_tr[27], ad_tr[27], 32'h4); else pass_cnt++;
    total_cnt++; if (wd_tr[27] !== 32'h33) $display("FAIL jalr_st_data: got %h want %h", wd_tr[27], 32'h33); else pass_cnt++;
    total_cnt++; if (we_count(0, 27) !== 2) $display("FAIL jal_we_count: got %0d want 2", we_count(0, 27)); else pass_cnt++;
  endtask

  task automatic test_alu();
    logic [31:0] exp_d [4];
    exp_d[0] = 32'hFFFF_FFEF; exp_d[1] = 32'h1; exp_d[2] = 32'h0; exp_d[3] = 32'hFFFF_FFFF;
    load_clear();
    imem[0] = enc_i(12'hFF0, 5'd0, 3'b000, 5'd6, 7'h13);
    imem[1] = enc_i(12'd1, 5'd0, 3'b000, 5'd7, 7'h13);
    imem[2] = enc_r(7'h20, 5'd7, 5'd6, 3'b000, 5'd11);
    imem[3] = enc_r(7'h00, 5'd7, 5'd6, 3'b010, 5'd12);
    imem[4] = enc_r(7'h00, 5'd7, 5'd6, 3'b011, 5'd13);
    imem[5] = enc_i(12'h404, 5'd6, 3'b101, 5'd14, 7'h13);
    for (int k = 0; k < 4; k++) imem[6 + k] = enc_s(12'(k * 4), 5'(11 + k), 5'd0);
    start();
    run_trace();
    for (int k = 0; k < 4; k++) begin
      total_cnt++;
      if (we_tr[9 + k] !== 1'b1 || ad_tr[9 + k] !== 32'(k * 4))
        $display("FAIL alu_st%0d_addr: got %b/%h want 1/%h", k, we_tr[9 + k], ad_tr[9 + k], 32'(k * 4));
      else pass_cnt++;
      total_cnt++;
      if (wd_tr[9 + k] !== exp_d[k]) $display("FAIL alu_res%0d: got %h want %h", k, wd_tr[9 + k], exp_d[k]);
      else pass_cnt++;
    end
  endtask

  task automatic test_x0();
    load_clear();
    imem[0] = enc_i(12'd5, 5'd0, 3'b000, 5'd0, 7'h13);
    imem[1] = enc_s(12'd16, 5'd0, 5'd0);
    start();
    run_trace();
    total_cnt++; if (we_tr[4] !== 1'b1 || ad_tr[4] !== 32'h10) $display("FAIL x0_st: got %b/%h want 1/%h", we_tr[4], ad_tr[4], 32'h10); else pass_cnt++;
    total_cnt++; if (wd_tr[4] !== 32'h0) $display("FAIL x0_data: got %h want %h", wd_tr[4], 32'h0); else pass_cnt++;
  endtask

  task automatic test_async_reset();
    load_clear();
    load_prog_fwd();
    start();
    repeat (6) @(negedge clk);
    #1;
    total_cnt++; if (we !== 1'b1) $display("FAIL arst_pre_we: got %b want 1", we); else pass_cnt++;
    rst = 1'b1;
    #1;
    total_cnt++; if (we !== 1'b0) $display("FAIL arst_we: got %b want 0", we); else pass_cnt++;
    total_cnt++; if (pfm_addr !== 32'h0) $display("FAIL arst_pfm: got %h want %h", pfm_addr, 32'h0); else pass_cnt++;
    total_cnt++; if (dfm_addr !== 32'h0) $display("FAIL arst_daddr: got %h want %h", dfm_addr, 32'h0); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_forward_store();
    test_load_use();
    test_branch();
    test_jal_jalr();
    test_alu();
    test_x0();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
